// File: rtl/operand_forward_stage.sv
// rtl/operand_forward_stage.sv - priority operand forwarding with load-use stall and valid/ready ID/EX slot
module operand_forward_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int CNTW  = 16,
  localparam int SELW = $clog2(NSRC + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         rs_addr,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic [NSRC-1:0]       fwd_valid,
  input  logic [NSRC*AW-1:0]    fwd_addr,
  input  logic [NSRC*WIDTH-1:0] fwd_data,
  input  logic [NSRC-1:0]       fwd_pending,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  stall_req,
  output logic [CNTW-1:0]       fwd_count
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic [CNTW-1:0]  r_count;

  logic             w_hit;
  logic             w_pend;
  logic [SELW-1:0]  w_sel;
  logic [WIDTH-1:0] w_data;
  logic             w_hazard;
  logic             w_accept;

  // Scan from oldest to youngest so the lowest matching index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_pend = 1'b0;
    w_sel  = '0;
    w_data = rf_data;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0)) begin
        w_hit  = 1'b1;
        w_pend = fwd_pending[i];
        w_sel  = SELW'(i + 1);
        w_data = fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_hazard  = in_valid && w_hit && w_pend;
  assign stall_req = w_hazard && !reset;
  assign in_ready  = (!r_valid || out_ready) && !w_hazard && !flush && !reset;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_count <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_sel;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      // Saturate rather than wrap so long runs still read as "many".
      if (w_accept && w_hit && (r_count != {CNTW{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign fwd_count = r_count;

endmodule

// File: tb/tb_operand_forward_stage.sv
// tb/tb_operand_forward_stage.sv - directed checks of operand_forward_stage
module tb_operand_forward_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [31:0] rf_data;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_pending;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        stall_req;
  logic [15:0] fwd_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_sel;
  logic        s_stall_req;
  logic [3:0]  s_fwd_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  operand_forward_stage u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel), .stall_req(stall_req),
    .fwd_count(fwd_count)
  );

  operand_forward_stage #(.CNTW(4)) u_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_sel(s_out_sel), .stall_req(s_stall_req),
    .fwd_count(s_fwd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    flush       = 1'b0;
    fwd_valid   = 2'b00;
    fwd_pending = 2'b00;
    fwd_addr    = '0;
    fwd_data    = '0;
    rs_addr     = '0;
    rf_data     = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Hazard-shaped request during reset must not stall or be ready
    rs_addr = 5'd5; in_valid = 1'b1;
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_pending = 2'b01;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_req, 0);
    tick(); tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_count", fwd_count, 0);

    // 1: no forwarding, register file source
    rs_addr = 5'd5; rf_data = 32'h11; in_valid = 1'b1;
    #1 chk("t1_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h11);
    chk("t1_sel", out_sel, 0);
    chk("t1_count", fwd_count, 0);

    // 2: both candidates match, youngest wins
    fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA}; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("t2_data", out_data, 32'hAA);
    chk("t2_sel", out_sel, 1);
    chk("t2_count", fwd_count, 1);
    // rs=0 never forwards
    rs_addr = 5'd0; fwd_addr = {5'd0, 5'd0}; rf_data = 32'h22; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("t2_r0_data", out_data, 32'h22);
    chk("t2_r0_sel", out_sel, 0);
    chk("t2_r0_count", fwd_count, 1);
    // only candidate 1 matches
    rs_addr = 5'd5; fwd_addr = {5'd5, 5'd3}; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("t2_c1_data", out_data, 32'hBB);
    chk("t2_c1_sel", out_sel, 2);
    chk("t2_c1_count", fwd_count, 2);
    // pending non-winner is ignored
    fwd_addr = {5'd5, 5'd5}; fwd_pending = 2'b10; in_valid = 1'b1;
    #1 chk("t2_nw_stall", stall_req, 0);
    tick(); in_valid = 1'b0; fwd_pending = 2'b00;
    chk("t2_nw_data", out_data, 32'hAA);
    chk("t2_nw_count", fwd_count, 3);

    // 3: load-use hazard for two cycles
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'hCC};
    fwd_pending = 2'b01; in_valid = 1'b1;
    #1;
    chk("t3_stall_a", stall_req, 1);
    chk("t3_ready_a", in_ready, 0);
    tick();
    chk("t3_stall_b", stall_req, 1);
    chk("t3_ready_b", in_ready, 0);
    chk("t3_drained", out_valid, 0);
    tick();
    fwd_pending = 2'b00;
    #1;
    chk("t3_stall_c", stall_req, 0);
    chk("t3_ready_c", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 32'hCC);
    chk("t3_count", fwd_count, 4);

    // 4: backpressure for 3 cycles, then pop+accept with no bubble
    fwd_valid = 2'b00; rs_addr = 5'd7; rf_data = 32'h33; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold_ready", in_ready, 0);
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 32'hCC);
    end
    out_ready = 1'b1;
    #1 chk("t4_pop_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("t4_nb_valid", out_valid, 1);
    chk("t4_nb_data", out_data, 32'h33);
    chk("t4_nb_sel", out_sel, 0);
    tick();
    chk("t4_pop_valid", out_valid, 0);
    chk("t4_pop_keep", out_data, 32'h33);

    // 5: flush with a would-be accept
    rs_addr = 5'd5; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'hDD};
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("t5_flush_ready", in_ready, 0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_count", fwd_count, 4);
    chk("t5_flush_keep", out_data, 32'h33);
    // flush of a held operand
    fwd_valid = 2'b00; rf_data = 32'h44; in_valid = 1'b1;
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_h_valid", out_valid, 1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t5_hflush_valid", out_valid, 0);
    chk("t5_hflush_data", out_data, 32'h44);
    // reset while holding
    fwd_valid = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_r_data", out_data, 32'hDD);
    chk("t5_r_count", fwd_count, 5);
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_sel", out_sel, 0);
    chk("t5_rst_count", fwd_count, 0);
    chk("t5_rst_scount", s_fwd_count, 0);

    // 6: saturation of a 4-bit counter after 20 forwarded accepts
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fwd_data = {32'h0, 32'(k + 256)};
      tick();
      if (k == 13) chk("t6_s14", s_fwd_count, 14);
      if (k == 14) chk("t6_s15", s_fwd_count, 15);
    end
    in_valid = 1'b0;
    chk("t6_sat", s_fwd_count, 15);
    chk("t6_wide", fwd_count, 20);
    chk("t6_last", s_out_data, 32'd275);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
